scan_seq_ctrl: RTL
==================

Name: scan_seq_ctrl

Overview:
- On-chip scan sequencer: the driving end of the fifo scan interface (TM, SI, SO).
- Runs one complete scan test per request:
  - serially loads a stimulus vector into the chain;
  - holds functional mode for a capture window;
  - unloads the chain and compares it against a masked expected value.
- Sits between a test/BIST host and the fifo; replaces bench-driven scan sequencing.

Parameters:
- LOAD_LEN, 25: bits shifted in per test (17 data + 3 wptr + 3 rptr + w_en + r_en).
- UNLOAD_LEN, 17: bits shifted out per test (data_out capture chain).
- CAPTURE_CYCLES, 1: functional-mode (TM=0) cycles between load and unload, ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a test; accepted in IDLE or DONE only.
- abort  in  1  synchronous abort; returns to IDLE; no done pulse.
- load_vec  in  LOAD_LEN  stimulus; load_vec[0] shifted first.
- expected  in  UNLOAD_LEN  expected unload value.
- mask  in  UNLOAD_LEN  1 = compare this bit.
- TM  out  1  scan test mode to DUT (1 = shift).
- SI  out  1  scan data to DUT.
- SO  in  1  scan data from DUT.
- busy  out  1  high from first LOAD cycle through last UNLOAD cycle.
- done  out  1  one-cycle pulse when result is valid.
- pass  out  1  ((captured ^ expected) & mask) == 0; held until next accepted start.
- captured  out  UNLOAD_LEN  unloaded bits; held until next accepted start.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- All outputs are registered.
- Reset values: TM=0, SI=0, busy=0, done=0, pass=0, captured=0; state=IDLE.
- FSM states: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
- Counter width: clog2(max(LOAD_LEN, UNLOAD_LEN, CAPTURE_CYCLES)+1).
- Acceptance: start sampled at edge E0 in IDLE/DONE latches load_vec, expected, mask, and clears captured and pass.
- Start during LOAD/CAPTURE/UNLOAD: ignored, no queuing.
- Cycle timeline, counting from E0 (cycle n is the cycle after the n-th edge):
  - Cycles 1..L (LOAD): TM=1, SI=load_vec[n-1].
  - Cycles L+1..L+C (CAPTURE): TM=0, SI=0.
  - Cycles L+C+1..L+C+U (UNLOAD): TM=1, SI=0.
  - During UNLOAD, SO is sampled at the edge ending each cycle; the k-th UNLOAD cycle's SO goes to captured[k].
  - Cycle L+C+U+1 (DONE): done=1, busy=0, TM=0, captured and pass valid.
- Leaving DONE: next cycle goes to IDLE, or to LOAD if start is sampled in DONE (back-to-back tests).
- pass is computed from the final captured value.
- abort (any state) → IDLE next cycle, TM=0, SI=0, busy=0, done=0, captured/pass unchanged.
- Precedence: abort and start in the same cycle → abort wins. rst overrides everything.
- rst mid-sequence → reset values next cycle; the DUT chain contents are undefined afterwards.
- Inputs load_vec, expected and mask may change while busy without effect.

Decomposition:
- Package scan_pkg holds:
  - state enum scan_state_t;
  - FIFO chain constants FIFO_DATA_W=17, FIFO_PTR_W=3, FIFO_LOAD_LEN=25, FIFO_UNLOAD_LEN=17;
  - chain field offsets: data [16:0], wptr [19:17], rptr [22:20], w_en [23], r_en [24].
- One sub-module, scan_unload_sr: UNLOAD_LEN capture register with a sample-enable and an index counter.

Test Plan:
- Loopback DUT model (SO = SI delayed 17 shift cycles, retained while TM=0), load_vec=25'h0155555 → captured equals load_vec bits [24:8] as reconstructed by the model; done exactly at cycle L+C+U+1 = 44.
- Real fifo after writing 0..6, load_vec=25'h12BFFFF (data all 1, wptr=5, rptr=2, w_en=0, r_en=1), expected=17'd2, mask=17'h1FFFF → captured=2, pass=1.
- Same run with expected=17'd3 → pass=0. Then with mask=17'h1FFFC → pass=1.
- TM trace check → TM=1 for cycles 1–25, 0 for 26, 1 for 27–43, 0 otherwise; SI matches load_vec bit order.
- abort asserted at cycle 10 → TM=0 and busy=0 at cycle 11, no done pulse; start at cycle 15 is accepted normally.
- start held high continuously → tests run back-to-back with one DONE cycle between; rst at cycle 30 → all outputs at reset values on cycle 31.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and FIFO scan-chain geometry for the scan sequencer.
package scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapture,
    StUnload,
    StDone
  } scan_state_t;

  localparam int unsigned FIFO_DATA_W     = 17;
  localparam int unsigned FIFO_PTR_W      = 3;
  localparam int unsigned FIFO_LOAD_LEN   = 25;
  localparam int unsigned FIFO_UNLOAD_LEN = 17;

  // Load-chain field offsets within load_vec (bit 0 shifted first).
  localparam int unsigned CHAIN_DATA_LSB = 0;
  localparam int unsigned CHAIN_DATA_MSB = 16;
  localparam int unsigned CHAIN_WPTR_LSB = 17;
  localparam int unsigned CHAIN_WPTR_MSB = 19;
  localparam int unsigned CHAIN_RPTR_LSB = 20;
  localparam int unsigned CHAIN_RPTR_MSB = 22;
  localparam int unsigned CHAIN_WEN_BIT  = 23;
  localparam int unsigned CHAIN_REN_BIT  = 24;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Host request/result signals plus the TM/SI/SO scan port of the sequencer.
interface scan_seq_ctrl_if #(
  parameter int unsigned LOAD_LEN   = scan_pkg::FIFO_LOAD_LEN,
  parameter int unsigned UNLOAD_LEN = scan_pkg::FIFO_UNLOAD_LEN
) ();
  import scan_pkg::*;

  logic                  start;
  logic                  abort;
  logic [LOAD_LEN-1:0]   load_vec;
  logic [UNLOAD_LEN-1:0] expected;
  logic [UNLOAD_LEN-1:0] mask;
  logic                  TM;
  logic                  SI;
  logic                  SO;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [UNLOAD_LEN-1:0] captured;

  modport master (
    input  start, abort, load_vec, expected, mask, SO,
    output TM, SI, busy, done, pass, captured
  );

  modport slave (
    output start, abort, load_vec, expected, mask, SO,
    input  TM, SI, busy, done, pass, captured
  );

endinterface

// File: rtl/scan_unload_sr.sv
// Unload capture register: each enabled sample writes sdi at the running index.
module scan_unload_sr
  import scan_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_UNLOAD_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_next
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    if (clear) begin
      data_d = '0;
      idx_d  = '0;
    end else if (sample_en) begin
      data_d[idx_q] = sdi;
      idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
    end
  end

  assign data      = data_q;
  assign data_next = data_d;

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan sequencer: load stimulus, hold capture window, unload and masked-compare.
module scan_seq_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned LOAD_LEN       = FIFO_LOAD_LEN,
  parameter int unsigned UNLOAD_LEN     = FIFO_UNLOAD_LEN,
  parameter int unsigned CAPTURE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  scan_seq_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(max3(LOAD_LEN, UNLOAD_LEN, CAPTURE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] CAPT_LAST = CNT_W'(CAPTURE_CYCLES - 1);
  localparam logic [CNT_W-1:0] UNLD_LAST = CNT_W'(UNLOAD_LEN - 1);

  scan_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LOAD_LEN-1:0]   vec_sh_q, vec_sh_d;
  logic [UNLOAD_LEN-1:0] exp_q, exp_d;
  logic [UNLOAD_LEN-1:0] mask_q, mask_d;
  logic tm_q, tm_d, si_q, si_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic                  accept;
  logic                  sr_clear, sr_sample;
  logic [UNLOAD_LEN-1:0] sr_data, sr_next;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = bus.start ? StLoad : StIdle;
        cnt_d   = '0;
      end
      StLoad: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = StCapture;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCapture: begin
        if (cnt_q == CAPT_LAST) begin
          state_d = StUnload;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StUnload: begin
        if (cnt_q == UNLD_LAST) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (bus.abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  assign accept = (state_d == StLoad) && ((state_q == StIdle) || (state_q == StDone));

  // Output/datapath next values, decoded from the upcoming state so outputs stay registered.
  always_comb begin
    tm_d      = (state_d == StLoad) || (state_d == StUnload);
    busy_d    = (state_d == StLoad) || (state_d == StCapture) || (state_d == StUnload);
    done_d    = (state_d == StDone);
    si_d      = 1'b0;
    vec_sh_d  = vec_sh_q;
    exp_d     = exp_q;
    mask_d    = mask_q;
    pass_d    = pass_q;
    sr_clear  = 1'b0;
    sr_sample = (state_q == StUnload) && !bus.abort;
    if (accept) begin
      si_d     = bus.load_vec[0];
      vec_sh_d = bus.load_vec >> 1;
      exp_d    = bus.expected;
      mask_d   = bus.mask;
      pass_d   = 1'b0;
      sr_clear = 1'b1;
    end else if (state_d == StLoad) begin
      si_d     = vec_sh_q[0];
      vec_sh_d = vec_sh_q >> 1;
    end
    // sr_next already holds the final unload bit on this edge.
    if ((state_q == StUnload) && (state_d == StDone)) begin
      pass_d = ((sr_next ^ exp_q) & mask_q) == '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tm_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      vec_sh_q <= '0;
      exp_q    <= '0;
      mask_q   <= '0;
    end else begin
      tm_q     <= tm_d;
      si_q     <= si_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      vec_sh_q <= vec_sh_d;
      exp_q    <= exp_d;
      mask_q   <= mask_d;
    end
  end

  scan_unload_sr #(
    .WIDTH(UNLOAD_LEN)
  ) u_unload_sr (
    .clk      (clk),
    .rst      (rst),
    .clear    (sr_clear),
    .sample_en(sr_sample),
    .sdi      (bus.SO),
    .data     (sr_data),
    .data_next(sr_next)
  );

  assign bus.TM       = tm_q;
  assign bus.SI       = si_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.captured = sr_data;

endmodule
